// File: rtl/ram_dma_pkg.sv
// ============================================================================
//  ram_dma_pkg : shared types and constants for the ramDmaCi DMA engine
//  Rev 1.0
// ============================================================================
`default_nettype none

package ram_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQUEST  = 3'd1,
    S_BEGIN    = 3'd2,
    S_READ     = 3'd3,
    S_PREFETCH = 3'd4,
    S_WRITE    = 3'd5,
    S_WEND     = 3'd6,
    S_NEXT     = 3'd7
  } dma_state_e;

  localparam logic [2:0] SEL_BUS_ADDR   = 3'd0;
  localparam logic [2:0] SEL_MEM_ADDR   = 3'd1;
  localparam logic [2:0] SEL_BLOCK_SIZE = 3'd2;
  localparam logic [2:0] SEL_BURST_SIZE = 3'd3;
  localparam logic [2:0] SEL_CONTROL    = 3'd4;
  localparam logic [2:0] SEL_STATUS     = 3'd5;

  localparam int CTRL_TO_MEM_BIT = 0;
  localparam int CTRL_TO_BUS_BIT = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_ERROR_BIT  = 1;

  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

endpackage

`default_nettype wire

// File: rtl/ram_dma_controller_if.sv
// ============================================================================
//  ram_dma_controller_if : config, system-bus and SSRAM port-B signal bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface ram_dma_controller_if #(
  parameter int addrWidth = 9
);
  logic                 cfgWe;
  logic [2:0]           cfgSel;
  logic [31:0]          cfgData;
  logic [31:0]          cfgReadData;
  logic                 busy;
  logic                 requestTransaction;
  logic                 transactionGranted;
  logic                 beginTransactionOut;
  logic [31:0]          addressDataOut;
  logic [3:0]           byteEnablesOut;
  logic [7:0]           burstSizeOut;
  logic                 readNotWriteOut;
  logic                 dataValidOut;
  logic                 endTransactionOut;
  logic [31:0]          addressDataIn;
  logic                 dataValidIn;
  logic                 endTransactionIn;
  logic                 busyIn;
  logic                 busErrorIn;
  logic [addrWidth-1:0] memAddressB;
  logic                 memWriteEnableB;
  logic [31:0]          memDataOutB;
  logic [31:0]          memDataInB;

  modport master (
    input  cfgWe, cfgSel, cfgData, transactionGranted, addressDataIn, dataValidIn,
           endTransactionIn, busyIn, busErrorIn, memDataInB,
    output cfgReadData, busy, requestTransaction, beginTransactionOut, addressDataOut,
           byteEnablesOut, burstSizeOut, readNotWriteOut, dataValidOut, endTransactionOut,
           memAddressB, memWriteEnableB, memDataOutB
  );

  modport slave (
    output cfgWe, cfgSel, cfgData, transactionGranted, addressDataIn, dataValidIn,
           endTransactionIn, busyIn, busErrorIn, memDataInB,
    input  cfgReadData, busy, requestTransaction, beginTransactionOut, addressDataOut,
           byteEnablesOut, burstSizeOut, readNotWriteOut, dataValidOut, endTransactionOut,
           memAddressB, memWriteEnableB, memDataOutB
  );

endinterface

`default_nettype wire

// File: rtl/ram_dma_cfg_regs.sv
// ============================================================================
//  ram_dma_cfg_regs : DMA config register file, readback mux and start pulse
//  Rev 1.0
// ============================================================================
`default_nettype none

module ram_dma_cfg_regs
  import ram_dma_pkg::*;
#(
  parameter int addrWidth = 9,
  parameter int maxBurst  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfgWe_i,
  input  logic [2:0]           cfgSel_i,
  input  logic [31:0]          cfgData_i,
  input  logic                 busy_i,
  input  logic                 error_i,
  output logic [31:0]          busAddress_o,
  output logic [addrWidth-1:0] memAddress_o,
  output logic [9:0]           blockSize_o,
  output logic [7:0]           burstSize_o,
  output logic                 start_o,
  output logic                 startToMem_o,
  output logic [31:0]          cfgReadData_o
);

  localparam logic [7:0] BURST_LIMIT = 8'(maxBurst - 1);

  logic                 wrEn;
  logic [29:0]          busAddress_q;
  logic [addrWidth-1:0] memAddress_q;
  logic [9:0]           blockSize_q;
  logic [7:0]           burstSize_q;
  logic [31:0]          cfgReadData_q, cfgReadData_d;

  assign wrEn = cfgWe_i & ~busy_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      busAddress_q  <= '0;
      memAddress_q  <= '0;
      blockSize_q   <= '0;
      burstSize_q   <= '0;
      cfgReadData_q <= '0;
    end else begin
      cfgReadData_q <= cfgReadData_d;
      if (wrEn) begin
        case (cfgSel_i)
          SEL_BUS_ADDR:   busAddress_q <= cfgData_i[31:2];
          SEL_MEM_ADDR:   memAddress_q <= cfgData_i[addrWidth-1:0];
          SEL_BLOCK_SIZE: blockSize_q  <= cfgData_i[9:0];
          SEL_BURST_SIZE: burstSize_q  <= (cfgData_i[7:0] > BURST_LIMIT) ? BURST_LIMIT
                                                                        : cfgData_i[7:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cfgReadData_d = '0;
    case (cfgSel_i)
      SEL_BUS_ADDR:   cfgReadData_d = {busAddress_q, 2'b00};
      SEL_MEM_ADDR:   cfgReadData_d = 32'(memAddress_q);
      SEL_BLOCK_SIZE: cfgReadData_d = 32'(blockSize_q);
      SEL_BURST_SIZE: cfgReadData_d = 32'(burstSize_q);
      SEL_STATUS: begin
        cfgReadData_d[STAT_BUSY_BIT]  = busy_i;
        cfgReadData_d[STAT_ERROR_BIT] = error_i;
      end
      default: ;
    endcase
  end

  // Bus->SSRAM wins when both direction bits are set.
  assign start_o       = wrEn && (cfgSel_i == SEL_CONTROL) &&
                         (cfgData_i[CTRL_TO_MEM_BIT] || cfgData_i[CTRL_TO_BUS_BIT]);
  assign startToMem_o  = cfgData_i[CTRL_TO_MEM_BIT];
  assign busAddress_o  = {busAddress_q, 2'b00};
  assign memAddress_o  = memAddress_q;
  assign blockSize_o   = blockSize_q;
  assign burstSize_o   = burstSize_q;
  assign cfgReadData_o = cfgReadData_q;

endmodule

`default_nettype wire

// File: rtl/ram_dma_controller.sv
// ============================================================================
//  ram_dma_controller : DMA between SSRAM port B and the system bus (bursts)
//  Rev 1.0
// ============================================================================
`default_nettype none

module ram_dma_controller
  import ram_dma_pkg::*;
#(
  parameter int nrOfEntries = 512,
  parameter int maxBurst    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  ram_dma_controller_if.master io
);

  localparam int addrWidth = $clog2(nrOfEntries);

  dma_state_e           state_q, state_d;
  logic [31:0]          busAddr_q, busAddr_d, wrData_q, wrData_d;
  logic [addrWidth-1:0] memAddr_q, memAddr_d;
  logic [9:0]           remaining_q, remaining_d, beats_q, beats_d, count_q, count_d;
  logic                 toMem_q, toMem_d, error_q, error_d;
  logic                 busy, start, startToMem;
  logic [31:0]          busAddress;
  logic [addrWidth-1:0] memAddress;
  logic [9:0]           blockSize, burstBeats, beatsNext;
  logic [7:0]           burstSize;

  assign busy    = (state_q != S_IDLE);
  assign io.busy = busy;

  ram_dma_cfg_regs #(.addrWidth(addrWidth), .maxBurst(maxBurst)) u_cfg (
    .clock(clock), .reset(reset),
    .cfgWe_i(io.cfgWe), .cfgSel_i(io.cfgSel), .cfgData_i(io.cfgData),
    .busy_i(busy), .error_i(error_q),
    .busAddress_o(busAddress), .memAddress_o(memAddress),
    .blockSize_o(blockSize), .burstSize_o(burstSize),
    .start_o(start), .startToMem_o(startToMem),
    .cfgReadData_o(io.cfgReadData)
  );

  assign burstBeats = 10'(burstSize) + 10'd1;
  assign beatsNext  = (burstBeats < remaining_q) ? burstBeats : remaining_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busAddr_q   <= '0;
      wrData_q    <= '0;
      memAddr_q   <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      count_q     <= '0;
      toMem_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      busAddr_q   <= busAddr_d;
      wrData_q    <= wrData_d;
      memAddr_q   <= memAddr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      count_q     <= count_d;
      toMem_q     <= toMem_d;
      error_q     <= error_d;
    end
  end

  // SSRAM->bus: memAddr_q tracks the word held in wrData_q, so port B looks
  // one word ahead (two when a beat is accepted) to keep the next word ready.
  always_comb begin
    state_d     = state_q;
    busAddr_d   = busAddr_q;
    wrData_d    = wrData_q;
    memAddr_d   = memAddr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    count_d     = count_q;
    toMem_d     = toMem_q;
    error_d     = error_q;

    io.requestTransaction  = 1'b0;
    io.beginTransactionOut = 1'b0;
    io.addressDataOut      = '0;
    io.byteEnablesOut      = '0;
    io.burstSizeOut        = '0;
    io.readNotWriteOut     = 1'b0;
    io.dataValidOut        = 1'b0;
    io.endTransactionOut   = 1'b0;
    io.memAddressB         = memAddr_q;
    io.memWriteEnableB     = 1'b0;
    io.memDataOutB         = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (blockSize != 10'd0) begin
            state_d     = S_REQUEST;
            busAddr_d   = busAddress;
            memAddr_d   = memAddress;
            remaining_d = blockSize;
            toMem_d     = startToMem;
          end
        end
      end
      S_REQUEST: begin
        io.requestTransaction = 1'b1;
        if (io.transactionGranted) begin
          state_d = S_BEGIN;
          beats_d = beatsNext;
          count_d = '0;
        end
      end
      S_BEGIN: begin
        io.requestTransaction  = 1'b1;
        io.beginTransactionOut = 1'b1;
        io.addressDataOut      = busAddr_q;
        io.byteEnablesOut      = BYTE_EN_ALL;
        io.burstSizeOut        = 8'(beats_q - 10'd1);
        io.readNotWriteOut     = toMem_q;
        state_d                = toMem_q ? S_READ : S_PREFETCH;
      end
      S_READ: begin
        io.requestTransaction = 1'b1;
        io.memDataOutB        = io.addressDataIn;
        if (io.dataValidIn && (count_q < beats_q)) begin
          io.memWriteEnableB = 1'b1;
          memAddr_d          = memAddr_q + addrWidth'(1);
          count_d            = count_q + 10'd1;
        end
        if (io.endTransactionIn) state_d = S_NEXT;
      end
      S_PREFETCH: begin
        io.requestTransaction = 1'b1;
        io.memAddressB        = memAddr_q + addrWidth'(1);
        wrData_d              = io.memDataInB;
        state_d               = S_WRITE;
      end
      S_WRITE: begin
        io.requestTransaction = 1'b1;
        io.dataValidOut       = 1'b1;
        io.addressDataOut     = wrData_q;
        if (!io.busyIn) begin
          io.memAddressB = memAddr_q + addrWidth'(2);
          wrData_d       = io.memDataInB;
          memAddr_d      = memAddr_q + addrWidth'(1);
          count_d        = count_q + 10'd1;
          if (count_q == beats_q - 10'd1) state_d = S_WEND;
        end else begin
          io.memAddressB = memAddr_q + addrWidth'(1);
        end
      end
      S_WEND: begin
        io.requestTransaction = 1'b1;
        io.endTransactionOut  = 1'b1;
        state_d               = S_NEXT;
      end
      S_NEXT: begin
        busAddr_d   = busAddr_q + {20'd0, beats_q, 2'b00};
        remaining_d = remaining_q - beats_q;
        state_d     = (remaining_q == beats_q) ? S_IDLE : S_REQUEST;
      end
      default: state_d = S_IDLE;
    endcase

    if (busy && io.busErrorIn) begin
      state_d = S_IDLE;
      error_d = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: doc/ram_dma_controller.md
Name: ram_dma_controller

Overview:
DMA engine that owns port B of the ramDmaCi dual-port SSRAM and moves word blocks between that SSRAM and the system bus.
- Configured by the custom-instruction front end through a small register file.
- Direction bus->SSRAM: bus read bursts, each beat written to port B.
- Direction SSRAM->bus: port B read, beats streamed as bus write bursts.

Parameters:
nrOfEntries, 512, SSRAM depth in 32-bit words; addrWidth = $clog2(nrOfEntries)
maxBurst, 16, largest burst in words; burstSizeOut = beats-1

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
cfgWe  in  1  one-cycle config write strobe
cfgSel  in  3  0 busAddress, 1 memAddress, 2 blockSize, 3 burstSize, 4 control, 5 status (read-only)
cfgData  in  32  config write data
cfgReadData  out  32  registered readback of register cfgSel
busy  out  1  transfer in progress
requestTransaction  out  1  bus request
transactionGranted  in  1  bus grant
beginTransactionOut  out  1  one-cycle address phase
addressDataOut  out  32  address in address phase, write data afterwards
byteEnablesOut  out  4  4'hF in address phase, else 0
burstSizeOut  out  8  beats-1 in address phase, else 0
readNotWriteOut  out  1  1 = bus read, valid in address phase
dataValidOut  out  1  write beat valid
endTransactionOut  out  1  one cycle after last write beat
addressDataIn  in  32  read data
dataValidIn  in  1  read beat valid
endTransactionIn  in  1  slave ends read burst
busyIn  in  1  slave stall, write beat must hold
busErrorIn  in  1  bus error
memAddressB  out  addrWidth  SSRAM port B address
memWriteEnableB  out  1  SSRAM port B write enable
memDataOutB  out  32  data to SSRAM dataInB
memDataInB  in  32  SSRAM dataOutB, valid one cycle after address

Behaviour:
- Reset: every output 0; all config registers 0; state IDLE. Reset mid-transfer aborts at the next edge with no endTransactionOut.
- Config registers:
  - busAddress: [31:2], [1:0] forced 0.
  - memAddress: addrWidth bits.
  - blockSize: 10 bits, words.
  - burstSize: 8 bits, beats-1, clamped to maxBurst-1.
- Config writes while busy are ignored.
- control write: bit0 starts bus->SSRAM; bit1 starts SSRAM->bus; both set = bus->SSRAM. Status = {30'b0, error, busy}.
- Start with blockSize 0: no bus activity, busy stays 0, error cleared.
- Otherwise the start clears error, sets busy the next cycle, and loads the working copies busAddr, memAddr and remaining.
- States:
  - IDLE -> REQUEST.
  - REQUEST: requestTransaction=1 until transactionGranted, then -> BEGIN.
  - BEGIN: one cycle, beginTransactionOut=1, beats = min(burstSize+1, remaining).
  - From BEGIN -> READ, or -> PREFETCH for SSRAM->bus.
  - READ: each dataValidIn writes addressDataIn to memAddr (memWriteEnableB=1, same cycle) and increments memAddr. endTransactionIn -> NEXT.
  - PREFETCH: one cycle of SSRAM latency.
  - WRITE: one beat per cycle while busyIn=0. While busyIn=1, dataValidOut and addressDataOut hold. After the last beat -> WEND.
  - WEND: one cycle, endTransactionOut=1 -> NEXT.
  - NEXT: busAddr += 4*beats, remaining -= beats. remaining=0 -> IDLE with busy=0, else -> REQUEST.
- requestTransaction is held from REQUEST through the end of the burst.
- memAddr wraps modulo nrOfEntries. busAddr wraps at 2^32.
- busErrorIn in any non-IDLE state: next cycle all bus outputs 0, error=1, busy=0, state IDLE. Remaining words are abandoned.
- Extra dataValidIn beyond beats is ignored, no SSRAM write.
- Write streaming never skips or duplicates a word under arbitrary busyIn patterns.

Decomposition:
- Package ram_dma_pkg holds:
  - the state enum;
  - cfgSel codes;
  - control/status bit positions;
  - the 4'hF byte-enable constant.
- One sub-module, ram_dma_cfg_regs: config register file, clamping, readback mux and start pulse. The FSM/datapath stays in the top.

Test Plan:
- Bus->SSRAM, busAddress 0x1000, memAddress 0, blockSize 8, burstSize 3 -> two bursts at 0x1000 and 0x1010, burstSizeOut 3. SSRAM words 0..7 equal the slave data. busy falls after the second endTransactionIn.
- SSRAM->bus, memAddress 510, blockSize 4, burstSize 15, preloaded words 510,511,0,1 -> one write burst, burstSizeOut 3, data in that order (wrap). endTransactionOut one cycle after the 4th beat.
- SSRAM->bus with busyIn high on beats 2 and 3 for 2 cycles each -> each word appears exactly once; addressDataOut stable during stalls.
- busErrorIn on the 2nd read beat of a 4-beat burst -> status reads 2'b10, all bus outputs 0 the next cycle. A new start clears error.
- blockSize 0 start -> no requestTransaction, busy stays 0. cfgWe to busAddress while busy -> readback unchanged.
- reset asserted mid-write-burst -> all outputs 0 next cycle, no endTransactionOut, status 0.
